// File: rtl/press_pulse_gen.sv
// press_pulse_gen: player-move pulse generator for the tug-of-war light chain.
// Each raw, active-low, asynchronous button goes through a synchronizer, a
// debounce FSM and press-edge detection. The two press events are then merged:
// if both land in the same cycle, both are dropped (a tie). While freeze is
// high, all pulses are masked.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   key_l_n  raw left button, 0 = pressed, asynchronous
//   key_r_n  raw right button, 0 = pressed, asynchronous
//   freeze   game-over hold; masks L/R while high
//   L, R     single-cycle move pulses, registered
//   l_held   debounced left level, 1 = pressed, registered
//   r_held   debounced right level, 1 = pressed, registered

// press_pulse_chan: one button channel (synchronizer + debounce FSM).
//   clk, reset   as top level
//   key_n_i      raw active-low button
//   raw_pulse_o  combinational; high in the cycle before the FSM enters HELD
//   held_o       registered debounced level (HELD or REL_WAIT)
//
// state      | meaning
// IDLE       | debounced released
// PRESS_WAIT | press seen, counting stable pressed samples
// HELD       | debounced pressed (also the reset state)
// REL_WAIT   | release seen, counting stable released samples
module press_pulse_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic raw_pulse_o,
  output logic held_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pressed;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   held_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
  end

  assign s_pressed = ~sync_q[SYNC_STAGES-1];

  // Starting in HELD means a button held through reset must first be seen
  // released before a press can count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HELD;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= (state_d == HELD) || (state_d == REL_WAIT);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    raw_pulse_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s_pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = HELD;
          cnt_d       = '0;
          raw_pulse_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s_pressed) begin
          state_d = REL_WAIT;
          cnt_d   = CW'(1);
        end
      end
      REL_WAIT: begin
        if (s_pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = HELD;
        cnt_d   = '0;
      end
    endcase
  end

  assign held_o = held_q;

endmodule

module press_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic l_held,
  output logic r_held
);

  logic raw_pulse_l, raw_pulse_r;
  logic l_q, l_d, r_q, r_d;

  press_pulse_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_l (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (key_l_n),
    .raw_pulse_o(raw_pulse_l),
    .held_o     (l_held)
  );

  press_pulse_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_r (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (key_r_n),
    .raw_pulse_o(raw_pulse_r),
    .held_o     (r_held)
  );

  // Simultaneous presses cancel; nothing is queued for a later cycle.
  assign l_d = raw_pulse_l & ~raw_pulse_r & ~freeze;
  assign r_d = raw_pulse_r & ~raw_pulse_l & ~freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      l_q <= l_d;
      r_q <= r_d;
    end
  end

  assign L = l_q;
  assign R = r_q;

endmodule

// File: doc/press_pulse_gen.md
Name: press_pulse_gen

Overview:
- Producer side of the player-move interface for the tug-of-war light chain.
- Converts the two raw, active-low, asynchronous push-button inputs into clean single-cycle move pulses L and R, which drive every light cell.
- Per channel: synchronizer, debounce, press-edge detection.
- Shared: simultaneous-press cancellation and a game-over freeze.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain; legal range 2 or more.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples needed to accept a press or release; legal range 1 or more.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_l_n  in  1  raw left button; 0 = pressed; asynchronous to clk.
- key_r_n  in  1  raw right button; 0 = pressed; asynchronous to clk.
- freeze  in  1  game-over hold from the win detector; suppresses all move pulses while high.
- L  out  1  left-move pulse; high for exactly one cycle per accepted press.
- R  out  1  right-move pulse; high for exactly one cycle per accepted press.
- l_held  out  1  debounced left-button level; 1 = pressed.
- r_held  out  1  debounced right-button level; 1 = pressed.

Behaviour:
- Reset is synchronous, active-high; clock is clk. Every register updates only on posedge clk.
- Reset values:
  - Synchronizer flops load 1 (released).
  - Both channel FSMs go to HELD.
  - Debounce counters load 0.
  - L, R, l_held and r_held are 0.
- Reset to HELD is deliberate: a button held through reset must first be seen released before any press counts, so no pulse is produced for it.
- Synchronizer: key_x_n passes through SYNC_STAGES flops. s_x is the inverted output of the last flop (1 = pressed). Only s_x feeds the FSM.
- Channel FSM, one per side, with counter cnt of width clog2(DEBOUNCE_CYCLES+1):
  - IDLE (released): if s_x=1, go to PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT:
    - s_x=0 (bounce): go to IDLE with cnt=0.
    - s_x=1 and cnt=DEBOUNCE_CYCLES: go to HELD and raise raw_pulse_x for one cycle.
    - Otherwise: cnt increments.
  - HELD (pressed): if s_x=0, go to REL_WAIT with cnt=1; otherwise stay.
  - REL_WAIT:
    - s_x=1: go to HELD with cnt=0.
    - s_x=0 and cnt=DEBOUNCE_CYCLES: go to IDLE.
    - Otherwise: cnt increments.
- DEBOUNCE_CYCLES=1 case: PRESS_WAIT and REL_WAIT each last one cycle.
- Debounced level: l_held/r_held = 1 exactly while the FSM is in HELD or REL_WAIT (registered).
- Pulse output, registered:
  - L = raw_pulse_l & !raw_pulse_r & !freeze.
  - R = raw_pulse_r & !raw_pulse_l & !freeze.
  - When both sides qualify in the same cycle, both pulses are dropped; that is a tie and no move.
  - A pulse is never deferred or queued.
- Latency: key_l_n low and stable from sampling edge k gives L=1 for exactly the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge k+6.
- Holding a button produces exactly one pulse; no auto-repeat. A new pulse needs a debounced release first.
- Freeze:
  - FSMs keep running while freeze is high, so state tracks the buttons; only the pulses are masked.
  - A press completed during freeze is lost.
  - Releasing freeze while a button is held produces no pulse.
- Reset mid-debounce or mid-pulse: the next cycle shows the reset values, and the partial count is discarded.
- L and R are never both 1 in any cycle.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset 3 cycles with both keys released, then key_l_n=0 from edge 10 and held for 20 cycles -> L=1 only in the cycle after edge 16; l_held=1 from edge 16; R stays 0.
- key_r_n low 3 cycles, high 1 cycle, then low 10 cycles (bounce) -> no pulse from the first burst; R=1 for one cycle 6 edges after the final fall; exactly one R pulse in total.
- Both keys fall at the same edge and stay low -> L=0 and R=0 throughout; l_held=r_held=1 after 6 edges. Right key falls 1 cycle after left -> L pulse, then R pulse one cycle later.
- key_l_n held low across reset deassertion -> no L pulse. Release for 6 or more cycles, then press -> one L pulse.
- freeze=1 while key_r_n is pressed and held -> R=0, r_held=1. Drop freeze while still held -> R stays 0. Release 6 cycles, press again -> one R pulse.
- Reset asserted 3 cycles into a press debounce -> outputs 0 the next cycle; after reset the held key yields no pulse until released and pressed again.
